bin_line_buf: RTL

- Parametrised multi-line buffer for 1-bit (binarised) video.
- Accepts one pixel per clock during active video and stores the previous LINES-1 rows in a single read-before-write RAM.
- Each input pixel produces one LINES-bit vertical column (current row plus LINES-1 rows above at the same x).
- Sits between the binarisation stage and the morphological erode/dilate / window stages. Generalises the fixed 2048x1 binary RAM to configurable width, line count and overflow handling.

---
 rtl/bin_line_buf_pkg.sv | 17 +
 rtl/sp_ram_rbw.sv | 38 +++
 rtl/bin_line_buf.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bin_line_buf_pkg.sv
// rtl/bin_line_buf_pkg.sv - shared defaults and edge helpers for the binary line buffer
package bin_line_buf_pkg;

    localparam int   DEF_ADDR_WIDTH = 11;
    localparam int   DEF_LINES      = 3;
    localparam int   DEF_MAX_PIX    = 1280;
    localparam logic DEF_FILL_VAL   = 1'b0;

    function automatic logic rose(input logic prev, input logic cur);
        return cur & ~prev;
    endfunction

    function automatic logic fell(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

endpackage

// File: rtl/sp_ram_rbw.sv
// rtl/sp_ram_rbw.sv - line RAM with registered read and separate read/write addresses
module sp_ram_rbw #(
    parameter int ADDR_WIDTH        = 11,
    parameter int DATA_WIDTH        = 2,
    parameter bit READ_BEFORE_WRITE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Contents are never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o <= '0;
        end else if (re_i) begin
            if (!READ_BEFORE_WRITE && we_i && (waddr_i == raddr_i)) begin
                rdata_o <= wdata_i;
            end else begin
                rdata_o <= mem_q[raddr_i];
            end
        end
    end

endmodule

// File: rtl/bin_line_buf.sv
// rtl/bin_line_buf.sv - multi-line buffer producing LINES-bit vertical columns of 1-bit video
module bin_line_buf
    import bin_line_buf_pkg::*;
#(
    parameter int   ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int   LINES      = DEF_LINES,
    parameter int   MAX_PIX    = DEF_MAX_PIX,
    parameter logic FILL_VAL   = DEF_FILL_VAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vs,
    input  logic                  i_de,
    input  logic                  i_bin,
    output logic                  o_de,
    output logic [LINES-1:0]      o_col,
    output logic [ADDR_WIDTH-1:0] o_x,
    output logic                  o_rows_ok,
    output logic                  o_ovf
);

    localparam int DW  = LINES - 1;
    localparam int LCW = $clog2(LINES);
    localparam int XW  = ADDR_WIDTH + 1;
    localparam logic [XW-1:0]  MAX_X     = XW'(MAX_PIX);
    localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES - 1);

    logic                  de_q, vs_q;
    logic [XW-1:0]         x_q, x_d, x_eff;
    logic [LCW-1:0]        line_cnt_q, line_cnt_d, lc_eff;
    logic                  ovf_q, ovf_d;
    logic                  out_de_q;
    logic [ADDR_WIDTH-1:0] out_x_q;
    logic                  bin_q;
    logic [DW-1:0]         mask_q, mask_d;
    logic [DW-1:0]         rd_data, wr_data;
    logic                  vs_rise, de_fall, accept;

    // A frame start overrides the running x/line state for the pixel on the same edge.
    always_comb begin
        vs_rise    = rose(vs_q, i_vs);
        de_fall    = fell(de_q, i_de);
        x_eff      = vs_rise ? '0 : x_q;
        lc_eff     = vs_rise ? '0 : line_cnt_q;
        accept     = i_de && (x_eff < MAX_X);

        x_d = x_eff;
        if (accept) begin
            x_d = x_eff + 1'b1;
        end else if (de_fall) begin
            x_d = '0;
        end

        line_cnt_d = lc_eff;
        if (de_fall && !vs_rise && (lc_eff != LAST_LINE)) begin
            line_cnt_d = lc_eff + 1'b1;
        end

        ovf_d = (vs_rise ? 1'b0 : ovf_q) | (i_de && !accept);

        mask_d = '0;
        for (int k = 1; k < LINES; k++) begin
            mask_d[k-1] = (lc_eff >= LCW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q       <= 1'b0;
            vs_q       <= 1'b0;
            x_q        <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
            out_de_q   <= 1'b0;
            out_x_q    <= '0;
            bin_q      <= 1'b0;
            mask_q     <= '0;
        end else begin
            de_q       <= i_de;
            vs_q       <= i_vs;
            x_q        <= x_d;
            line_cnt_q <= line_cnt_d;
            ovf_q      <= ovf_d;
            out_de_q   <= accept;
            if (accept) begin
                out_x_q <= x_eff[ADDR_WIDTH-1:0];
                bin_q   <= i_bin;
                mask_q  <= mask_d;
            end
        end
    end

    // Write-back lags the read by one cycle, at the address of the pixel now on the outputs.
    generate
        if (LINES == 2) begin : g_wr_one
            assign wr_data = bin_q;
        end else begin : g_wr_shift
            assign wr_data = {rd_data[DW-2:0], bin_q};
        end
    endgenerate

    sp_ram_rbw #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .DATA_WIDTH       (DW),
        .READ_BEFORE_WRITE(1'b1)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .re_i   (accept),
        .raddr_i(x_eff[ADDR_WIDTH-1:0]),
        .we_i   (out_de_q),
        .waddr_i(out_x_q),
        .wdata_i(wr_data),
        .rdata_o(rd_data)
    );

    assign o_de      = out_de_q;
    assign o_x       = out_x_q;
    assign o_col     = out_de_q ? {(rd_data & mask_q) | ({DW{FILL_VAL}} & ~mask_q), bin_q} : '0;
    assign o_rows_ok = (line_cnt_q == LAST_LINE);
    assign o_ovf     = ovf_q;

endmodule
